// File: rtl/aes_128_arbiter.sv
// aes_128_arbiter: round-robin sharing of one fixed-latency aes_128 pipeline; AES_ARB_STATS_EN adds issue/stall/wait counters
module aes_128_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 21,
   parameter int ID_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_state,
   input  logic [NUM_REQ*128-1:0] req_key,
   output logic [127:0]           core_state,
   output logic [127:0]           core_key,
   input  logic [127:0]           core_out,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [127:0]           rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
`ifdef AES_ARB_STATS_EN
   ,
   output logic [31:0]            issue_cnt,
   output logic [31:0]            stall_cnt,
   output logic [15:0]            max_wait
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gnt_id;
   logic gnt;
   logic [LATENCY-1:0] tag_v;
   logic [ID_W-1:0] tag_id [LATENCY];
   // round-robin search starting one past the last granted requester
   always_comb begin
      gnt = 1'b0;
      gnt_id = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (state == RUN && en && !gnt && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
            gnt = 1'b1;
            gnt_id = ID_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end
   assign req_ready = gnt ? NUM_REQ'(1) << gnt_id : '0;
   assign rsp_data = |rsp_valid ? core_out : '0;
   assign busy = state != IDLE || |tag_v || |rsp_valid;
   // control state; grants only happen in RUN, so DRAIN just waits for the pipe to empty
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= en ? RUN : (state == IDLE || !(|tag_v)) ? IDLE : DRAIN;
   end
   // core input registers, valid tag pipe, response register and pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= ID_W'(NUM_REQ - 1);
         core_state <= '0;
         core_key <= '0;
         tag_v <= '0;
         rsp_valid <= '0;
         rsp_id <= '0;
      end else begin
         ptr <= gnt ? gnt_id : ptr;
         core_state <= gnt ? req_state[128*gnt_id +: 128] : '0;
         core_key <= gnt ? req_key[128*gnt_id +: 128] : '0;
         tag_v <= {tag_v[LATENCY-2:0], gnt};
         rsp_valid <= tag_v[LATENCY-1] ? NUM_REQ'(1) << tag_id[LATENCY-1] : '0;
         rsp_id <= tag_v[LATENCY-1] ? tag_id[LATENCY-1] : rsp_id;
      end
   end
   // requester IDs travel alongside the valid bits; qualified by tag_v so no reset needed
   always_ff @(posedge clk) begin
      tag_id[0] <= gnt_id;
      for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
   end
`ifdef AES_ARB_STATS_EN
   logic [15:0] wait_cnt [NUM_REQ];
   // grant count, stalled RUN cycles and longest pre-grant wait
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
         max_wait <= '0;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      end else begin
         issue_cnt <= issue_cnt + 32'(gnt);
         stall_cnt <= stall_cnt + 32'(state == RUN && en && |req_valid && !gnt);
         for (int i = 0; i < NUM_REQ; i++)
            wait_cnt[i] <= (req_valid[i] && !req_ready[i]) ? (&wait_cnt[i] ? wait_cnt[i] : wait_cnt[i] + 16'd1) : '0;
         if (gnt && wait_cnt[gnt_id] > max_wait) max_wait <= wait_cnt[gnt_id];
      end
   end
`endif
endmodule

// File: tb/tb_aes_128_arbiter.sv
// tb_aes_128_arbiter: table, directed and random checks of aes_128_arbiter against an AES-128 core model and scoreboard
module tb_aes_128_arbiter;
   localparam int N = 4, L = 21, IW = 2;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
   logic [N*128-1:0] req_state = '0, req_key = '0;
   logic [127:0] core_state, core_key, core_out, rsp_data;
   logic [IW-1:0] rsp_id;
   logic busy;
`ifdef AES_ARB_STATS_EN
   logic [31:0] issue_cnt, stall_cnt;
   logic [15:0] max_wait;
`endif
   int checks = 0, failures = 0, cyc = 0, mode = 0, last = N - 1;
   typedef struct {int due; int id; logic [127:0] data;} exp_t;
   typedef struct {logic en; logic [N-1:0] rv; logic [N-1:0] exp;} vec_t;
   exp_t q[$];
   exp_t log_q[$];
   logic [N-1:0] grant_seen = '0, ready_smp = '0;
   logic busy_smp = 1'b0;
   logic [7:0] sbox [256];
   logic [127:0] cpipe [L] = '{default: '0};

   always #5 clk = ~clk;

   aes_128_arbiter #(.NUM_REQ(N), .LATENCY(L), .ID_W(IW)) dut (
      .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
      .req_state(req_state), .req_key(req_key), .core_state(core_state), .core_key(core_key),
      .core_out(core_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef AES_ARB_STATS_EN
      , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt), .max_wait(max_wait)
`endif
   );

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sb_calc(input logic [7:0] x);
      logic [7:0] v = 8'h01;
      for (int k = 0; k < 254; k++) v = gm(v, x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0] w [44];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [31:0] tmp;
      logic [7:0] rc = 8'h01;
      logic [127:0] o;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
               s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
            end else for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
            for (int j = 0; j < 4; j++) s[4*c+j] ^= w[4*r+c][31-8*j -: 8];
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   initial for (int x = 0; x < 256; x++) sbox[x] = sb_calc(8'(x));

   // fixed-latency core model: out valid LATENCY cycles after core_state/key are sampled
   always @(posedge clk) begin
      cpipe[0] <= aes_enc(core_state, core_key);
      for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
   end
   assign core_out = cpipe[L-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // one clock cycle: inputs already applied just after negedge; compare, then advance the model
   task automatic tick();
      logic [N-1:0] eg = '0;
      int gi = -1;
      exp_t e;
      #1;
      if (mode == 1 && en)
         for (int k = 1; k <= N; k++) if (gi < 0 && req_valid[(last + k) % N]) gi = (last + k) % N;
      if (gi >= 0) eg[gi] = 1'b1;
      chk("req_ready", 128'(req_ready), 128'(eg));
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("rsp_valid", 128'(rsp_valid), 128'(1) << q[0].id);
         chk("rsp_id", 128'(rsp_id), 128'(q[0].id));
         chk("rsp_data", rsp_data, q[0].data);
         void'(q.pop_front());
      end else chk("rsp_valid_quiet", 128'(rsp_valid), 128'(0));
      chk("busy", 128'(busy), 128'(mode != 0 || q.size() > 0));
      if (rsp_valid != '0) begin
         e.due = cyc; e.id = int'(rsp_id); e.data = rsp_data;
         log_q.push_back(e);
      end
      grant_seen = req_ready & req_valid;
      ready_smp = req_ready;
      busy_smp = busy;
      if (rst) begin
         q.delete(); mode = 0; last = N - 1;
      end else begin
         if (gi >= 0) begin
            e.due = cyc + 1 + L; e.id = gi; e.data = aes_enc(req_state[128*gi +: 128], req_key[128*gi +: 128]);
            q.push_back(e);
            last = gi;
         end
         mode = en ? 1 : (mode == 0 || !(q.size() > 0 && q[$].due > cyc)) ? 0 : 2;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   vec_t tbl [11];
   int g, fall;

   initial begin
      tbl[0]  = '{1'b1, 4'b0110, 4'b0000};
      tbl[1]  = '{1'b1, 4'b0110, 4'b0010};
      tbl[2]  = '{1'b1, 4'b0100, 4'b0100};
      tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[4]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[5]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[6]  = '{1'b0, 4'b1111, 4'b0000};
      tbl[7]  = '{1'b1, 4'b1111, 4'b0000};
      tbl[8]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[9]  = '{1'b1, 4'b0001, 4'b0001};
      tbl[10] = '{1'b1, 4'b0000, 4'b0000};
      @(negedge clk);
      do_reset();
      chk("reset_core_state", core_state, 128'(0));
      chk("reset_core_key", core_key, 128'(0));
      chk("reset_rsp_data", rsp_data, 128'(0));
      chk("reset_rsp_id", 128'(rsp_id), 128'(0));

      // single request with the FIPS-197 appendix B vector
      en = 1'b1; tick();
      req_state[127:0] = 128'h3243f6a8885a308d313198a2e0370734;
      req_key[127:0]   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      req_valid = 4'b0001; log_q.delete(); g = cyc;
      tick();
      req_valid = '0;
      ticks(L + 4);
      chk("single_count", 128'(log_q.size()), 128'(1));
      if (log_q.size() > 0) begin
         chk("single_cycle", 128'(log_q[0].due), 128'(g + 1 + L));
         chk("single_data", log_q[0].data, 128'h3925841d02dc09fbdc118597196a0b32);
         chk("single_id", 128'(log_q[0].id), 128'(0));
      end

      // arbitration table, beginning with requesters 1 and 2 contending from reset
      do_reset();
      req_state = '0; req_key = '0;
      req_state[255:128] = 128'h00112233445566778899aabbccddeeff;
      req_key[255:128]   = 128'h000102030405060708090a0b0c0d0e0f;
      req_state[383:256] = 128'hcafef00d_12345678_9abcdef0_0badbeef;
      req_key[383:256]   = 128'h0f0e0d0c0b0a09080706050403020100;
      log_q.delete();
      for (int r = 0; r < 11; r++) begin
         en = tbl[r].en; req_valid = tbl[r].rv;
         tick();
         chk($sformatf("table_row%0d", r), 128'(ready_smp), 128'(tbl[r].exp));
      end
      en = 1'b0; req_valid = '0;
      ticks(L + 4);
      chk("contend_count", 128'(log_q.size()), 128'(7));
      if (log_q.size() >= 2) begin
         chk("contend_id0", 128'(log_q[0].id), 128'(1));
         chk("contend_data0", log_q[0].data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
         chk("contend_id1", 128'(log_q[1].id), 128'(2));
         chk("contend_next", 128'(log_q[1].due), 128'(log_q[0].due + 1));
      end

      // fairness: all requesters held for 12 cycles
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_state[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
         req_key[128*i +: 128]   = {$urandom, $urandom, $urandom, $urandom};
      end
      en = 1'b1; tick();
      req_valid = '1; log_q.delete();
      for (int k = 0; k < 12; k++) begin
         tick();
         chk($sformatf("fair_grant%0d", k), 128'(grant_seen), 128'(1) << (k % N));
      end
      req_valid = '0;
      ticks(L + 4);
      chk("fair_count", 128'(log_q.size()), 128'(12));
      for (int k = 0; k < 12 && k < log_q.size(); k++) begin
         chk($sformatf("fair_rsp_id%0d", k), 128'(log_q[k].id), 128'(k % N));
         chk($sformatf("fair_rsp_cyc%0d", k), 128'(log_q[k].due), 128'(log_q[0].due + k));
      end
`ifdef AES_ARB_STATS_EN
      chk("issue_cnt", 128'(issue_cnt), 128'(12));
      chk("stall_cnt", 128'(stall_cnt), 128'(0));
      chk("max_wait", 128'(max_wait), 128'(3));
`endif

      // drain: three grants, en drops two cycles later, requester 3 then asks in vain
      do_reset();
      en = 1'b1; tick();
      req_valid = 4'b0111; log_q.delete();
      for (int k = 0; k < 3; k++) begin
         tick();
         req_valid &= ~grant_seen;
      end
      chk("drain_reqs_done", 128'(req_valid), 128'(0));
      tick();
      en = 1'b0; req_valid = 4'b1000; fall = -1;
      for (int k = 0; k < L + 6; k++) begin
         tick();
         if (fall < 0 && !busy_smp) fall = cyc - 1;
      end
      chk("drain_count", 128'(log_q.size()), 128'(3));
      if (log_q.size() == 3) chk("drain_busy_fall", 128'(fall), 128'(log_q[2].due + 1));
      en = 1'b1;
      ticks(2);
      req_valid = '0;
      ticks(L + 3);

      // reset five cycles after a grant discards the block
      do_reset();
      en = 1'b1; tick();
      req_state[127:0] = 128'h0123456789abcdef0123456789abcdef;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      ticks(4);
      rst = 1'b1; tick();
      rst = 1'b0; en = 1'b0; log_q.delete();
      tick();
      chk("rst_busy", 128'(busy_smp), 128'(0));
      ticks(L + 4);
      chk("rst_no_rsp", 128'(log_q.size()), 128'(0));
      en = 1'b1; tick();
      req_state[127:0] = '0; req_key[127:0] = '0; req_valid = 4'b0001;
      tick();
      req_valid = '0;
      ticks(L + 4);
      chk("post_rst_count", 128'(log_q.size()), 128'(1));
      if (log_q.size() > 0) chk("post_rst_data", log_q[0].data, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

      // random traffic with en toggling and occasional reset
      do_reset();
      en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 24) == 0) en = ~en;
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || grant_seen[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_state[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
               req_key[128*i +: 128]   = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
         end
         tick();
      end
      rst = 1'b0; en = 1'b0; req_valid = '0;
      ticks(L + 4);
      chk("random_drained", 128'(q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_128_arbiter.md
Name: aes_128_arbiter

Overview:
- Round-robin scheduler that shares one fully pipelined aes_128 core (one block accepted per cycle, fixed latency) among NUM_REQ requesters.
- Grants at most one request per cycle, registers the granted state/key into the core, and tracks requester ID alongside the core pipeline with a valid/ID shift register.
- Routes each ciphertext back to its originating requester.
- Sits between on-chip clients and the aes_128 instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 21, cycles from core state/key sampled to core out valid. Must match the aes_128 instance.
- ID_W, 2, requester ID width. Must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = issue allowed; 0 = stop granting, drain in-flight blocks
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_state  in  NUM_REQ*128  plaintext, requester i at [128*i+127:128*i]
- req_key  in  NUM_REQ*128  key, same packing
- core_state  out  128  registered plaintext to aes_128.state
- core_key  out  128  registered key to aes_128.key
- core_out  in  128  aes_128.out
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse; no backpressure
- rsp_data  out  128  ciphertext; valid only when rsp_valid != 0
- rsp_id  out  ID_W  ID of current response
- busy  out  1  1 while any block is in flight or state != IDLE

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - core_state = 0, core_key = 0, busy = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Tag pipe all invalid.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: en=1.
  - RUN -> DRAIN: en=0 and any tag valid.
  - RUN -> IDLE: en=0 and pipe empty.
  - DRAIN -> RUN: en=1.
  - DRAIN -> IDLE: last tag exits and en=0.
- Arbitration:
  - req_ready is combinational from req_valid and RR pointer. It is nonzero only in RUN.
  - At most one bit is set, and only where req_valid is set.
  - Search order starts at pointer+1 mod NUM_REQ.
  - Pointer updates to the granted index on a grant; otherwise it holds.
- Issue, grant in cycle t:
  - core_state/core_key load the granted requester's words at the edge ending t.
  - The tag pipe stage 0 loads {valid=1, id}.
  - With no grant, core_state/core_key load 0 and stage 0 loads invalid. Inputs are zeroed so idle traffic is deterministic.
- Tag pipe:
  - LATENCY stages, shifting every cycle unconditionally; the core cannot stall.
  - The tail aligns with core_out.
- Response for a grant in cycle t:
  - rsp_valid[id] pulses in cycle t+1+LATENCY.
  - rsp_data = core_out and rsp_id = id in that cycle.
  - Fixed latency, in-order, and every grant yields exactly one response.
- Back-to-back grants give back-to-back responses at full rate, one per cycle.
- A requester must hold req_valid/state/key stable until granted. Dropping req_valid before grant is legal: no transfer occurs.
- en falling in the same cycle as a potential grant: no grant that cycle.
- busy = (state != IDLE) | any tag valid.
- rst mid-operation:
  - Tag pipe is cleared; in-flight blocks are discarded with no rsp_valid.
  - The core's internal pipeline is unaffected, but its outputs are ignored.
- Width rule: rsp_id is zero-extended index; unused ID codes are never produced.

Optional Feature:
- Macro: AES_ARB_STATS_EN.
- Defined:
  - Adds output issue_cnt, 32 bits: grants since reset, wraps at 2^32.
  - Adds output stall_cnt, 32 bits: cycles in RUN with any req_valid high but no grant; never nonzero in the base design, kept as a check.
  - Adds output max_wait, 16 bits: largest number of cycles any requester held req_valid before grant; saturating.
  - All three reset to 0.
- Undefined: ports and logic absent; behaviour is otherwise identical.

Test Plan:
- Single request, en=1: req 0 sends state 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> rsp_valid[0] at grant+1+LATENCY, rsp_data 3925841d02dc09fbdc118597196a0b32, rsp_id 0.
- Contention: req 1 and req 2 valid in the same cycle from reset, req 1 with state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> req 1 granted first, then req 2 the next cycle.
  - Response for req 1: rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 1.
  - Response for req 2 follows on the next cycle.
- Fairness: all 4 requesters held valid for 12 cycles -> grant order 0,1,2,3 repeated, each granted 3 times; 12 consecutive responses in the same order.
- Drain: en drops 2 cycles after 3 grants -> no new req_ready, 3 responses still delivered, busy falls the cycle after the last response, state returns to IDLE.
- Reset mid-flight: rst asserted for 1 cycle 5 cycles after a grant -> no rsp_valid for that block, busy = 0 after reset.
  - Next request after reset completes normally with correct data, e.g. state 0, key 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- With AES_ARB_STATS_EN: the fairness scenario -> issue_cnt = 12, stall_cnt = 0, max_wait = 3.
